// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/lap/done FSM, tick prescaler and the enable
// cascade that drives a chain of external digit counters.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              lap,
    input  logic              mode_down,
    input  logic [DIGITS-1:0] threshold,
    output logic [DIGITS-1:0] cnt_enable,
    output logic              up_down,
    output logic              cnt_clear,
    output logic              lap_hold,
    output logic              running,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_LAP,
        S_DONE
    } state_t;

    localparam logic [DIV_BITS-1:0] PRESC_MAX = DIV_BITS'(TICK_DIV - 1);

    state_t              state;
    state_t              state_nxt;
    logic [DIV_BITS-1:0] presc;
    logic                active;
    logic                tick;
    logic                term;
    logic                ud_chg;
    logic [DIGITS-1:0]   en;

    always_comb begin
        active = (state == S_RUN) || (state == S_LAP);
        tick   = active && (presc == PRESC_MAX);
        term   = tick && (&threshold);

        // Terminal count suppresses every enable so the counters never wrap.
        en    = '0;
        en[0] = tick && !term;
        for (int i = 1; i < DIGITS; i++) begin
            en[i] = en[i-1] & threshold[i-1];
        end
        cnt_enable = en;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else if (term) begin
            state_nxt = S_DONE;
        end else begin
            case (state)
                S_IDLE:  if (start_stop) state_nxt = S_RUN;
                S_RUN: begin
                    if (start_stop)  state_nxt = S_PAUSE;
                    else if (lap)    state_nxt = S_LAP;
                end
                S_LAP: begin
                    if (start_stop)  state_nxt = S_PAUSE;
                    else if (lap)    state_nxt = S_RUN;
                end
                S_PAUSE: if (start_stop) state_nxt = S_RUN;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            running  <= 1'b0;
            done     <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            running  <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
            done     <= (state_nxt == S_DONE);
            lap_hold <= (state_nxt == S_LAP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (active) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Direction is latched only in IDLE; a change reloads the counters one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_down   <= 1'b1;
            ud_chg    <= 1'b0;
            cnt_clear <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                up_down <= !mode_down;
            end
            ud_chg    <= (state == S_IDLE) && (up_down != !mode_down);
            cnt_clear <= clear || ud_chg;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (TICK_DIV=4, DIGITS=2): directed sequences with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DIGITS   = 2;
    localparam int DIV_BITS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;
    localparam int M_DONE  = 4;

    logic              clk;
    logic              rst;
    logic              start_stop;
    logic              clear;
    logic              lap;
    logic              mode_down;
    logic [DIGITS-1:0] threshold;
    logic [DIGITS-1:0] cnt_enable;
    logic              up_down;
    logic              cnt_clear;
    logic              lap_hold;
    logic              running;
    logic              done;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    stopwatch_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DIGITS  (DIGITS),
        .DIV_BITS(DIV_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .mode_down (mode_down),
        .threshold (threshold),
        .cnt_enable(cnt_enable),
        .up_down   (up_down),
        .cnt_clear (cnt_clear),
        .lap_hold  (lap_hold),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: mode, position within the tick period, direction, reload pulse.
    int                ms;
    int                phase;
    bit                m_up;
    bit                m_pend;
    bit                m_clr;
    int                ms_n;
    int                phase_n;
    bit                up_n;
    bit                pend_n;
    bit                clr_n;
    bit                m_active;
    bit                m_tick;
    bit                m_term;
    int                n_on;
    logic [DIGITS-1:0] exp_en;

    always_comb begin
        m_active = (ms == M_RUN) || (ms == M_LAP);
        m_tick   = m_active && (phase == TICK_DIV - 1);
        m_term   = m_tick && (threshold == '1);
        n_on     = 0;
        exp_en   = '0;
        if (m_tick && !m_term) begin
            n_on = 1;
            for (int k = 0; k < DIGITS - 1; k++) begin
                if (n_on == k + 1 && threshold[k]) n_on = k + 2;
            end
            exp_en = DIGITS'((1 << n_on) - 1);
        end

        ms_n = ms;
        if (clear) ms_n = M_IDLE;
        else if (m_term) ms_n = M_DONE;
        else if (start_stop) begin
            if (ms == M_IDLE || ms == M_PAUSE) ms_n = M_RUN;
            else if (ms == M_RUN || ms == M_LAP) ms_n = M_PAUSE;
        end else if (lap) begin
            if (ms == M_RUN) ms_n = M_LAP;
            else if (ms == M_LAP) ms_n = M_RUN;
        end

        phase_n = clear ? 0 : (m_active ? (phase + 1) % TICK_DIV : phase);
        up_n    = (ms == M_IDLE) ? !mode_down : m_up;
        pend_n  = (ms == M_IDLE) && ((!mode_down) != m_up);
        clr_n   = clear || m_pend;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms     <= M_IDLE;
            phase  <= 0;
            m_up   <= 1'b1;
            m_pend <= 1'b0;
            m_clr  <= 1'b0;
        end else begin
            ms     <= ms_n;
            phase  <= phase_n;
            m_up   <= up_n;
            m_pend <= pend_n;
            m_clr  <= clr_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cnt_enable", 32'(cnt_enable), 32'(exp_en));
            chk("up_down", 32'(up_down), 32'(m_up));
            chk("cnt_clear", 32'(cnt_clear), 32'(m_clr));
            chk("lap_hold", 32'(lap_hold), 32'(ms == M_LAP));
            chk("running", 32'(running), 32'(ms == M_RUN || ms == M_LAP));
            chk("done", 32'(done), 32'(ms == M_DONE));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step();
        lap = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Cycles from now (current cycle = 1) until an enable appears; bounded.
    task automatic wait_tick(output int n);
        n = 1;
        #2;
        while (cnt_enable == '0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ticks;
        rst = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
        mode_down = 1'b0;
        threshold = '0;
        repeat (3) step();
        cmp_on = 1'b1;

        settle();
        chk("rst_cnt_enable", 32'(cnt_enable), 32'd0);
        chk("rst_up_down", 32'(up_down), 32'd1);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();
        rst = 1'b1;
        step();
        settle();
        chk("release_cnt_clear", 32'(cnt_clear), 32'd0);
        step();

        // Basic up run: one enable per TICK_DIV cycles.
        pulse_ss();
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (cnt_enable == 2'b01) ticks++;
            step();
        end
        chk("basic_ticks", 32'(ticks), 32'd3);
        chk("basic_running", 32'(running), 32'd1);

        // Cascade on a tick cycle.
        wait_tick(n);
        threshold = 2'b01;
        #1;
        chk("cascade_11", 32'(cnt_enable), 32'd3);
        step();
        threshold = 2'b00;
        wait_tick(n);
        chk("cascade_period", 32'(n), 32'd4);
        chk("cascade_01", 32'(cnt_enable), 32'd1);
        step();

        // Pause after two RUN cycles, resume after ten.
        pulse_clear();
        settle();
        chk("clear_cnt_clear", 32'(cnt_clear), 32'd1);
        pulse_ss();
        step();
        pulse_ss();
        repeat (10) step();
        settle();
        chk("pause_running", 32'(running), 32'd0);
        pulse_ss();
        wait_tick(n);
        chk("resume_first_tick", 32'(n), 32'd2);

        // Terminal count with a coincident start_stop.
        step();
        wait_tick(n);
        chk("term_period", 32'(n), 32'd4);
        threshold = 2'b11;
        start_stop = 1'b1;
        #1;
        chk("term_enable", 32'(cnt_enable), 32'd0);
        step();
        start_stop = 1'b0;
        threshold = 2'b00;
        settle();
        chk("term_done", 32'(done), 32'd1);
        chk("term_running", 32'(running), 32'd0);
        pulse_ss();
        settle();
        chk("done_ignores_ss", 32'(done), 32'd1);
        pulse_lap();
        settle();
        chk("done_ignores_lap", 32'(lap_hold), 32'd0);

        // Clear coincident with terminal count.
        pulse_clear();
        pulse_ss();
        wait_tick(n);
        threshold = 2'b11;
        clear = 1'b1;
        step();
        clear = 1'b0;
        threshold = 2'b00;
        settle();
        chk("clr_term_done", 32'(done), 32'd0);
        chk("clr_term_cnt_clear", 32'(cnt_clear), 32'd1);

        // Lap freeze, lap exit through pause, then clear beats start_stop.
        step();
        pulse_ss();
        step();
        pulse_lap();
        settle();
        chk("lap_hold_on", 32'(lap_hold), 32'd1);
        chk("lap_running", 32'(running), 32'd1);
        wait_tick(n);
        chk("lap_tick", 32'(cnt_enable), 32'd1);
        step();
        pulse_ss();
        settle();
        chk("lap_pause_hold", 32'(lap_hold), 32'd0);
        pulse_ss();
        pulse_lap();
        clear = 1'b1;
        start_stop = 1'b1;
        step();
        clear = 1'b0;
        start_stop = 1'b0;
        settle();
        chk("prio_running", 32'(running), 32'd0);
        chk("prio_cnt_clear", 32'(cnt_clear), 32'd1);
        chk("prio_lap_hold", 32'(lap_hold), 32'd0);
        step();
        settle();
        chk("prio_clear_once", 32'(cnt_clear), 32'd0);

        // Direction change in IDLE, ignored in RUN.
        mode_down = 1'b1;
        step();
        settle();
        chk("mode_up_down", 32'(up_down), 32'd0);
        chk("mode_no_clear_yet", 32'(cnt_clear), 32'd0);
        step();
        settle();
        chk("mode_cnt_clear", 32'(cnt_clear), 32'd1);
        step();
        settle();
        chk("mode_clear_ends", 32'(cnt_clear), 32'd0);

        // Down-mode terminal count.
        pulse_ss();
        wait_tick(n);
        threshold = 2'b11;
        step();
        threshold = 2'b00;
        settle();
        chk("down_done", 32'(done), 32'd1);
        chk("down_dir", 32'(up_down), 32'd0);
        pulse_clear();
        mode_down = 1'b0;
        repeat (3) step();
        pulse_ss();
        mode_down = 1'b1;
        repeat (6) step();
        settle();
        chk("run_mode_ignored", 32'(up_down), 32'd1);
        mode_down = 1'b0;

        // Reset asserted mid-RUN.
        step();
        rst = 1'b0;
        settle();
        chk("midrst_running", 32'(running), 32'd0);
        chk("midrst_enable", 32'(cnt_enable), 32'd0);
        threshold = 2'b01;
        repeat (8) step();
        threshold = 2'b00;
        rst = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000: clk cycles per count tick; legal values are 2 or more.
REQ-002 Parameter DIGITS, default 4: number of cascaded digit counters sequenced.
REQ-003 Parameter DIV_BITS, default 20: prescaler width; it SHALL satisfy 2^DIV_BITS >= TICK_DIV.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_stop  input  1  single-cycle synchronous pulse: start, pause or resume.
REQ-007 clear  input  1  single-cycle synchronous pulse: return to IDLE and zero the counters.
REQ-008 lap  input  1  single-cycle synchronous pulse: toggle display freeze while running.
REQ-009 mode_down  input  1  1 = count down, 0 = count up; sampled only in IDLE.
REQ-010 threshold  input  DIGITS  per-digit terminal flags from the counters (bit i = digit i).
REQ-011 cnt_enable  output  DIGITS  per-digit count enables.
REQ-012 up_down  output  1  direction to all counters: 1 = up.
REQ-013 cnt_clear  output  1  one-cycle pulse that reloads the counters.
REQ-014 lap_hold  output  1  display freeze request.
REQ-015 running  output  1  high in RUN and LAP.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, PAUSE, LAP and DONE.
REQ-018 Event priority SHALL be clear > start_stop > lap.
- Only the highest-priority event asserted in a cycle acts.
REQ-019 clear SHALL act the same from every state:
- next state is IDLE;
- cnt_clear pulses for 1 cycle;
- the prescaler is zeroed;
- lap_hold drops.
REQ-020 IDLE transitions:
- start_stop -> RUN;
- lap is ignored.
REQ-021 RUN transitions:
- start_stop -> PAUSE;
- lap -> LAP.
REQ-022 LAP transitions:
- start_stop -> PAUSE, and lap_hold drops;
- lap -> RUN.
REQ-023 PAUSE transitions:
- start_stop -> RUN;
- lap is ignored.
REQ-024 DONE transitions:
- only clear exits DONE;
- start_stop and lap are ignored.
REQ-025 up_down SHALL equal the inverse of the registered mode_down, registered only while in IDLE.
- A change of up_down while in IDLE SHALL produce a 1-cycle cnt_clear on the cycle after the change.
REQ-026 Prescaler behaviour:
- it SHALL count 0..TICK_DIV-1 only in RUN and LAP;
- it SHALL hold its value in PAUSE and DONE;
- tick = (prescaler == TICK_DIV-1) while in RUN or LAP, after which it wraps to 0.
REQ-027 Count enables:
- cnt_enable[0] = tick;
- cnt_enable[i] = cnt_enable[i-1] & threshold[i-1] for i >= 1;
- both are combinational from the registered state and the prescaler, plus the threshold input.
REQ-028 Terminal count SHALL apply when tick is high and threshold is all ones, in either direction:
- cnt_enable SHALL be forced to all zeros, so there is no wrap;
- next state SHALL be DONE.
REQ-029 Terminal-count boundary cases:
- A start_stop in the same cycle as terminal count SHALL be ignored; DONE wins.
- A clear in the same cycle SHALL win over DONE.
REQ-030 lap_hold SHALL be 1 exactly while in LAP.
REQ-031 running and done SHALL be registered and SHALL decode directly from the state.
REQ-032 cnt_enable SHALL be all zeros in IDLE, PAUSE and DONE.

Reset
REQ-033 While rst is low, the block SHALL hold these values:
- state = IDLE;
- prescaler = 0;
- up_down = 1;
- cnt_clear = 0;
- lap_hold = 0;
- running = 0;
- done = 0;
- cnt_enable = 0.
REQ-034 Reset release SHALL require no pulse on cnt_clear.
- The counters own their reset.
REQ-035 Assertion of reset mid-RUN SHALL abort immediately, with no further cnt_enable pulses.

Verification (TICK_DIV=4, DIGITS=2)
REQ-036 Basic run, up mode:
- stimulus: start_stop, hold threshold=00;
- response: cnt_enable=01 for one cycle in every 4 cycles, running=1.
REQ-037 Cascade:
- stimulus: RUN, threshold=01 on a tick cycle;
- response: cnt_enable=11 on that cycle; with threshold=00 the response is 01.
REQ-038 Terminal count:
- stimulus: RUN, threshold=11 at tick;
- response: cnt_enable=00, done=1 on the next cycle, and start_stop then has no effect.
REQ-039 Pause and resume:
- stimulus: start_stop after 2 cycles of RUN, wait 10 cycles, then start_stop;
- response: the first tick arrives 2 cycles after resume.
REQ-040 Lap and priority:
- stimulus: lap in RUN, then clear and start_stop in the same cycle;
- response: lap_hold=1 and ticks continue; then state = IDLE, cnt_clear pulses once, running=0.
REQ-041 Mode change:
- stimulus: in IDLE set mode_down=1;
- response: up_down=0 next cycle, then a 1-cycle cnt_clear.
- stimulus: set mode_down in RUN;
- response: no change to up_down.
